node_vector_demux: RTL and testbench

- Distributor for node_vector_T traffic: accepts one vector per cycle on a valid/ready input stream tagged with a 2-bit destination, and routes it to one of four output lanes.
- Each lane has a small FIFO and its own valid/ready handshake.
- Sits upstream of the four per-lane consumers, the other end of the 4:1 lane-select muxes that gather results back.
- Keeps a per-lane delivered-vector count for debug and throughput checks.

---
 rtl/node_vector_demux_pkg.sv | 21 ++
 rtl/node_vector_fifo.sv | 71 +++++++
 rtl/node_vector_demux.sv | 89 ++++++++
 tb/tb_node_vector_demux.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/node_vector_demux_pkg.sv
// node_vector_demux_pkg
// Shared types and constants for the node_vector lane distributor.
//   NUM_LANES     : number of output lanes, tied to the 2-bit destination tag
//   lane_sel_T    : destination lane selector
//   lane_count_T  : per-lane delivered-vector counter, used as unsigned 32-bit
//   node_vector_T : vector payload carried through the distributor
package node_vector_demux_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_sel_T;

  typedef int lane_count_T;

  // Payload of one node vector: two 16-bit components.
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } node_vector_T;

endpackage

// File: rtl/node_vector_fifo.sv
// node_vector_fifo
// Small synchronous FIFO holding node vectors for a single lane.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous flush, wins over push and pop
//   push     : write wdata (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   wdata    : vector to store
//   rdata    : head-of-FIFO vector, zero while empty
//   full     : no free entry
//   empty    : no stored entry
module node_vector_fifo
  import node_vector_demux_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  node_vector_T wdata,
  output node_vector_T rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates the full and empty cases when the
  // index bits match.
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  node_vector_T mem_r [DEPTH];

  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty = (wr_ptr_r == rd_ptr_r);

  // Pointer and storage update; clear only rewinds the pointers since the
  // read port masks stale entries while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push && !full) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Head read from registered storage, forced to zero when nothing is held.
  always_comb begin
    if (empty) begin
      rdata = '0;
    end else begin
      rdata = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

endmodule

// File: rtl/node_vector_demux.sv
// node_vector_demux
// Routes a valid/ready stream of node vectors to one of four lane FIFOs by
// destination tag and counts vectors delivered on each lane.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronous flush of all FIFOs and counters
//   in_valid   : input vector present
//   in_ready   : input accepted this cycle when high with in_valid
//   in_dest    : destination lane
//   in_data    : vector payload
//   out_valid  : per-lane data present
//   out_ready  : per-lane consumer ready
//   out_data   : per-lane head-of-FIFO payload
//   lane_count : per-lane delivered-vector count (wraps, unsigned)
module node_vector_demux
  import node_vector_demux_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  lane_sel_T            in_dest,
  input  node_vector_T         in_data,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready,
  output node_vector_T         out_data [NUM_LANES],
  output lane_count_T          lane_count [NUM_LANES]
);

  logic [NUM_LANES-1:0] full_s;
  logic [NUM_LANES-1:0] empty_s;
  logic [NUM_LANES-1:0] push_s;
  logic [NUM_LANES-1:0] pop_s;

  // Ready depends only on the addressed lane's occupancy and clear, so an
  // input headed for a full lane stalls the whole stream (no reordering).
  always_comb begin
    in_ready = !full_s[in_dest] && !clear;
  end

  // One-hot push toward the addressed lane on an accepted transfer.
  always_comb begin
    push_s = '0;
    if (in_valid && in_ready) begin
      push_s[in_dest] = 1'b1;
    end else begin
      push_s = '0;
    end
  end

  assign pop_s     = ~empty_s & out_ready;
  assign out_valid = ~empty_s;

  for (genvar g = 0; g < NUM_LANES; g++) begin : gen_lane
    lane_count_T count_r;

    node_vector_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .push (push_s[g]),
      .pop  (pop_s[g]),
      .wdata(in_data),
      .rdata(out_data[g]),
      .full (full_s[g]),
      .empty(empty_s[g])
    );

    // Delivered-vector counter; a pop in a clear cycle is not counted.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count_r <= 32'sd0;
      end else if (clear) begin
        count_r <= 32'sd0;
      end else if (pop_s[g]) begin
        count_r <= count_r + 32'sd1;
      end else begin
        count_r <= count_r;
      end
    end

    assign lane_count[g] = count_r;
  end

endmodule

// File: tb/tb_node_vector_demux.sv
// tb_node_vector_demux
// Self-checking bench for node_vector_demux: per-lane queues model the
// distributor, directed scenarios pin key behaviour, then random traffic.
module tb_node_vector_demux;
  import node_vector_demux_pkg::*;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  lane_sel_T    in_dest;
  node_vector_T in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  node_vector_T out_data [4];
  lane_count_T  lane_count [4];

  node_vector_demux #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .lane_count(lane_count)
  );

  always #5 clk = ~clk;

  // Reference model: one queue and one unsigned counter per lane.
  node_vector_T mq [4][$];
  int unsigned  cnt [4];
  bit           last_acc;
  bit           pend;
  lane_sel_T    pend_dest;
  node_vector_T pend_data;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      cnt[i] = 0;
    end
    pend     = 1'b0;
    last_acc = 1'b0;
  endtask

  task automatic compare();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(mq[i].size() != 0));
      if (mq[i].size() != 0) begin
        chk($sformatf("out_data[%0d]", i), out_data[i], mq[i][0]);
      end
      chk($sformatf("lane_count[%0d]", i), lane_count[i], cnt[i]);
    end
    chk("in_ready", 32'(in_ready), 32'(!clear && (mq[in_dest].size() < DEPTH)));
  endtask

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic model_update();
    bit acc;
    acc = in_valid && !clear && (mq[in_dest].size() < DEPTH);
    if (clear) begin
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mq[i].size() != 0 && out_ready[i]) begin
          void'(mq[i].pop_front());
          cnt[i]++;
        end
      end
      if (acc) mq[in_dest].push_back(in_data);
    end
    last_acc  = acc;
    pend      = in_valid && !acc && !clear;
    pend_dest = in_dest;
    pend_data = in_data;
  endtask

  // Called at a falling edge with inputs already set; returns at the next one.
  task automatic step();
    #1;
    compare();
    if (pend) begin
      assert (in_valid && in_dest == pend_dest && in_data == pend_data)
        else $error("input changed while stalled");
    end
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input lane_sel_T d, input node_vector_T v);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_dest  = d;
    in_data  = v;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      done = last_acc;
    end
    chk("send_accept", 32'(done), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic async_reset();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("arst_count[%0d]", i), lane_count[i], 32'h0);
      chk($sformatf("arst_data[%0d]", i), out_data[i], 32'h0);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_dest   = 2'd0;
    in_data   = 32'h0;
    out_ready = 4'b0000;
    model_reset();

    // Reset / idle
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_count[%0d]", i), lane_count[i], 32'h0);
      chk($sformatf("rst_data[%0d]", i), out_data[i], 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    step();

    // Single route to lane 2
    out_ready = 4'b1111;
    send(2'd2, 32'hA5A5_0001);
    chk("route_valid", 32'(out_valid), 32'h4);
    chk("route_data", out_data[2], 32'hA5A5_0001);
    step();
    chk("route_count", lane_count[2], 32'd1);
    chk("route_idle", 32'(out_valid), 32'h0);

    // Back-pressure on lane 1
    out_ready = 4'b1101;
    send(2'd1, 32'h0000_00AA);
    send(2'd1, 32'h0000_00BB);
    in_valid = 1'b1;
    in_dest  = 2'd1;
    in_data  = 32'h0000_00CC;
    step();
    chk("bp_stall", 32'(in_ready), 32'h0);
    chk("bp_headA", out_data[1], 32'h0000_00AA);
    out_ready = 4'b1111;
    step();
    chk("bp_headB", out_data[1], 32'h0000_00BB);
    chk("bp_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("bp_headC", out_data[1], 32'h0000_00CC);
    step();
    step();
    chk("bp_count", lane_count[1], 32'd3);

    // Lane independence with head-of-line blocking
    out_ready = 4'b0000;
    send(2'd0, 32'h1000_0001);
    send(2'd0, 32'h1000_0002);
    send(2'd3, 32'h3000_0001);
    send(2'd3, 32'h3000_0002);
    out_ready = 4'b1000;
    in_valid  = 1'b1;
    in_dest   = 2'd0;
    in_data   = 32'h1000_0003;
    step();
    chk("hol_lane3_valid", 32'(out_valid[3]), 32'h1);
    chk("hol_lane3_data", out_data[3], 32'h3000_0002);
    chk("hol_stall", 32'(in_ready), 32'h0);
    step();
    chk("hol_lane0_full", 32'(out_valid), 32'h1);
    out_ready = 4'b1111;
    step();
    step();
    in_valid = 1'b0;
    send(2'd3, 32'h3000_0003);
    repeat (4) step();

    // Counter wrap
    out_ready = 4'b0000;
    send(2'd0, 32'h0BAD_F00D);
    force dut.gen_lane[0].count_r = 32'hFFFF_FFFF;
    #1;
    release dut.gen_lane[0].count_r;
    cnt[0] = 32'hFFFF_FFFF;
    out_ready = 4'b0001;
    step();
    chk("wrap_count", lane_count[0], 32'h0);

    // Clear with a simultaneous push
    out_ready = 4'b0000;
    send(2'd0, 32'h0000_0010);
    send(2'd0, 32'h0000_0011);
    send(2'd1, 32'h0000_0020);
    send(2'd1, 32'h0000_0021);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_dest  = 2'd2;
    in_data  = 32'hDEAD_BEEF;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("clr_count[%0d]", i), lane_count[i], 32'h0);
    step();

    // Async reset while lanes hold data
    send(2'd0, 32'h0000_0030);
    send(2'd3, 32'h0000_0031);
    async_reset();
    out_ready = 4'b1111;
    send(2'd1, 32'h0000_0040);
    step();
    chk("post_rst_count", lane_count[1], 32'd1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if (n == 300) async_reset();
      if (!pend) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_dest  = lane_sel_T'($urandom_range(0, 3));
        in_data  = node_vector_T'($urandom);
      end
      out_ready = 4'($urandom);
      clear     = ($urandom_range(0, 39) == 0);
      step();
    end
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
